// File: rtl/coin_payment_frontend.sv
// Coin payment front-end: collects credit toward a single or double wash,
// starts the washer controller, returns change and refunds on cancel/timeout.
module coin_payment_frontend #(
    parameter int PRICE_SINGLE = 100,
    parameter int PRICE_DOUBLE = 150,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_code,
    input  logic       double_wash_req,
    input  logic       cancel,
    input  logic       wash_done,
    output logic       coin_in,
    output logic       double_wash,
    output logic       busy,
    output logic [7:0] credit,
    output logic       change_valid,
    output logic [7:0] change_amount,
    output logic       coin_reject
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        START   = 3'd2,
        RUNNING = 3'd3,
        REFUND  = 3'd4
    } state_t;

    localparam int TIMER_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(IDLE_TIMEOUT - 1);
    localparam logic [7:0] PRICE_S = 8'(PRICE_SINGLE);
    localparam logic [7:0] PRICE_D = 8'(PRICE_DOUBLE);

    function automatic logic [7:0] coin_value(input logic [1:0] code);
        case (code)
            2'b00:   coin_value = 8'd25;
            2'b01:   coin_value = 8'd50;
            2'b10:   coin_value = 8'd100;
            default: coin_value = 8'd0;
        endcase
    endfunction

    state_t               state, state_next;
    logic [TIMER_W-1:0]   timer, timer_next;
    logic [7:0]           credit_next;
    logic [7:0]           change_next;
    logic                 dbl, dbl_next;

    logic [7:0]           price;
    logic [7:0]           sum;
    logic                 coin_ok;

    logic                 coin_in_next;
    logic                 double_wash_next;
    logic                 busy_next;
    logic                 change_valid_next;
    logic                 coin_reject_next;

    // Credit is always 0 in IDLE, so one adder serves both IDLE and COLLECT.
    assign price   = double_wash_req ? PRICE_D : PRICE_S;
    assign sum     = credit + coin_value(coin_code);
    assign coin_ok = coin_valid && (coin_code != 2'b11) && !cancel &&
                     ((state == IDLE) || (state == COLLECT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            credit        <= '0;
            dbl           <= 1'b0;
            change_amount <= '0;
            coin_in       <= 1'b0;
            double_wash   <= 1'b0;
            busy          <= 1'b0;
            change_valid  <= 1'b0;
            coin_reject   <= 1'b0;
        end else begin
            state         <= state_next;
            timer         <= timer_next;
            credit        <= credit_next;
            dbl           <= dbl_next;
            change_amount <= change_next;
            coin_in       <= coin_in_next;
            double_wash   <= double_wash_next;
            busy          <= busy_next;
            change_valid  <= change_valid_next;
            coin_reject   <= coin_reject_next;
        end
    end

    always_comb begin
        state_next  = state;
        timer_next  = timer;
        credit_next = credit;
        dbl_next    = dbl;
        change_next = change_amount;
        unique case (state)
            IDLE, COLLECT: begin
                if ((state == COLLECT) && cancel) begin
                    state_next  = REFUND;
                    change_next = credit;
                end else if (coin_ok) begin
                    credit_next = sum;
                    timer_next  = '0;
                    if (sum >= price) begin
                        state_next  = START;
                        dbl_next    = double_wash_req;
                        change_next = sum - price;
                    end else begin
                        state_next  = COLLECT;
                    end
                end else if (state == COLLECT) begin
                    if (timer == TIMER_LAST) begin
                        state_next  = REFUND;
                        change_next = credit;
                    end else begin
                        timer_next = timer + TIMER_W'(1);
                    end
                end
            end
            START: begin
                credit_next = '0;
                state_next  = RUNNING;
            end
            RUNNING: begin
                if (wash_done) begin
                    state_next = IDLE;
                end
            end
            REFUND: begin
                credit_next = '0;
                timer_next  = '0;
                state_next  = IDLE;
            end
            default: begin
                state_next  = IDLE;
                credit_next = '0;
                timer_next  = '0;
            end
        endcase
    end

    // Outputs are registered from the upcoming state so each one lines up with it.
    always_comb begin
        coin_in_next      = (state_next == START);
        busy_next         = (state_next == START) || (state_next == RUNNING);
        double_wash_next  = busy_next && dbl_next;
        change_valid_next = ((state_next == START) && (change_next != 8'd0)) ||
                            (state_next == REFUND);
        coin_reject_next  = coin_valid && !coin_ok;
    end

endmodule

// File: tb/tb_coin_payment_frontend.sv
// Scenario bench for coin_payment_frontend; expected change/refund amounts are
// queued when the causing stimulus is driven and popped when change_valid fires.
module tb_coin_payment_frontend;

    localparam int PS = 100;
    localparam int PD = 150;
    localparam int TO = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_code = 2'b00;
    logic       double_wash_req = 1'b0;
    logic       cancel = 1'b0;
    logic       wash_done = 1'b0;
    logic       coin_in;
    logic       double_wash;
    logic       busy;
    logic [7:0] credit;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       coin_reject;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    coin_payment_frontend #(
        .PRICE_SINGLE(PS),
        .PRICE_DOUBLE(PD),
        .IDLE_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .coin_valid(coin_valid),
        .coin_code(coin_code),
        .double_wash_req(double_wash_req),
        .cancel(cancel),
        .wash_done(wash_done),
        .coin_in(coin_in),
        .double_wash(double_wash),
        .busy(busy),
        .credit(credit),
        .change_valid(change_valid),
        .change_amount(change_amount),
        .coin_reject(coin_reject)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_coin(input logic [1:0] code);
        coin_valid = 1'b1;
        coin_code  = code;
        tick();
        coin_valid = 1'b0;
        coin_code  = 2'b00;
    endtask

    task automatic pulse_wash_done();
        wash_done = 1'b1;
        tick();
        wash_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({coin_in, double_wash, busy, change_valid, coin_reject, credit, change_amount} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs actual=%h required=0",
                     {coin_in, double_wash, busy, change_valid, coin_reject, credit, change_amount});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({busy, credit} !== 9'd0) begin
            failures++;
            $display("FAIL reset_release_idle actual=%h required=0", {busy, credit});
        end
    endtask

    task automatic test_single_wash();
        double_wash_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drop_coin(2'b00);
            checks++;
            if (credit !== 8'(25 * (i + 1)) || coin_in !== 1'b0) begin
                failures++;
                $display("FAIL single_credit_step%0d actual=%0d/%b required=%0d/0",
                         i, credit, coin_in, 25 * (i + 1));
            end
            tick();
        end
        drop_coin(2'b00);
        checks++;
        if ({coin_in, double_wash, busy, change_valid} !== 4'b1010 || credit !== 8'd100) begin
            failures++;
            $display("FAIL single_start actual=%b credit=%0d required=1010 credit=100",
                     {coin_in, double_wash, busy, change_valid}, credit);
        end
        tick();
        checks++;
        if ({coin_in, busy} !== 2'b01 || credit !== 8'd0) begin
            failures++;
            $display("FAIL single_running actual=%b credit=%0d required=01 credit=0",
                     {coin_in, busy}, credit);
        end
        pulse_wash_done();
        checks++;
        if ({busy, double_wash} !== 2'b00) begin
            failures++;
            $display("FAIL single_done actual=%b required=00", {busy, double_wash});
        end
    endtask

    task automatic test_double_wash();
        int exp;
        double_wash_req = 1'b1;
        drop_coin(2'b10);
        checks++;
        if (credit !== 8'd100 || coin_in !== 1'b0) begin
            failures++;
            $display("FAIL double_no_early_start actual=%0d/%b required=100/0", credit, coin_in);
        end
        tick();
        exp_q.push_back(200 - PD);
        drop_coin(2'b10);
        checks++;
        if ({coin_in, double_wash, busy, change_valid} !== 4'b1111) begin
            failures++;
            $display("FAIL double_start actual=%b required=1111",
                     {coin_in, double_wash, busy, change_valid});
        end
        if (change_valid === 1'b1) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            checks++;
            if (int'(change_amount) !== exp) begin
                failures++;
                $display("FAIL double_change actual=%0d required=%0d", change_amount, exp);
            end
        end
        double_wash_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({double_wash, busy, coin_in, change_valid} !== 4'b1100) begin
                failures++;
                $display("FAIL double_hold%0d actual=%b required=1100",
                         i, {double_wash, busy, coin_in, change_valid});
            end
        end
        pulse_wash_done();
        checks++;
        if ({busy, double_wash} !== 2'b00) begin
            failures++;
            $display("FAIL double_done actual=%b required=00", {busy, double_wash});
        end
    endtask

    task automatic test_cancel();
        int exp;
        double_wash_req = 1'b0;
        drop_coin(2'b01);
        tick();
        exp_q.push_back(50);
        cancel = 1'b1;
        drop_coin(2'b00);
        cancel = 1'b0;
        checks++;
        if ({coin_reject, change_valid} !== 2'b11) begin
            failures++;
            $display("FAIL cancel_strobes actual=%b required=11", {coin_reject, change_valid});
        end
        if (change_valid === 1'b1) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            checks++;
            if (int'(change_amount) !== exp) begin
                failures++;
                $display("FAIL cancel_refund actual=%0d required=%0d", change_amount, exp);
            end
        end
        tick();
        checks++;
        if (credit !== 8'd0 || {change_valid, coin_reject, busy} !== 3'b000) begin
            failures++;
            $display("FAIL cancel_idle actual=%0d/%b required=0/000",
                     credit, {change_valid, coin_reject, busy});
        end
    endtask

    task automatic test_timeout();
        int exp;
        int n;
        double_wash_req = 1'b0;
        drop_coin(2'b00);
        repeat (TO / 2) tick();
        exp_q.push_back(50);
        drop_coin(2'b00);
        n = 0;
        for (int i = 1; i <= 3 * TO; i++) begin
            tick();
            if (change_valid === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n !== TO) begin
            failures++;
            $display("FAIL timeout_latency actual=%0d required=%0d", n, TO);
        end
        if (n != 0) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            checks++;
            if (int'(change_amount) !== exp) begin
                failures++;
                $display("FAIL timeout_refund actual=%0d required=%0d", change_amount, exp);
            end
        end
        tick();
        checks++;
        if (credit !== 8'd0 || change_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle actual=%0d/%b required=0/0", credit, change_valid);
        end
    endtask

    task automatic test_running_and_reject();
        int exp;
        double_wash_req = 1'b0;
        drop_coin(2'b10);
        checks++;
        if (coin_in !== 1'b1 || credit !== 8'd100 || change_valid !== 1'b0) begin
            failures++;
            $display("FAIL direct_start actual=%b/%0d/%b required=1/100/0",
                     coin_in, credit, change_valid);
        end
        tick();
        drop_coin(2'b01);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 8'd0) begin
            failures++;
            $display("FAIL running_reject actual=%b/%0d required=1/0", coin_reject, credit);
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tick();
        checks++;
        if ({busy, change_valid, coin_in} !== 3'b100) begin
            failures++;
            $display("FAIL running_cancel_ignored actual=%b required=100",
                     {busy, change_valid, coin_in});
        end
        pulse_wash_done();
        pulse_wash_done();
        drop_coin(2'b11);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 8'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_invalid_coin actual=%b/%0d/%b required=1/0/0",
                     coin_reject, credit, busy);
        end
        drop_coin(2'b01);
        checks++;
        if (credit !== 8'd50 || coin_reject !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_invalid actual=%0d/%b required=50/0", credit, coin_reject);
        end
        exp_q.push_back(50);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++;
        if (change_valid !== 1'b1) begin
            failures++;
            $display("FAIL cleanup_refund_strobe actual=%b required=1", change_valid);
        end else begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            checks++;
            if (int'(change_amount) !== exp) begin
                failures++;
                $display("FAIL cleanup_refund actual=%0d required=%0d", change_amount, exp);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        double_wash_req = 1'b0;
        for (int i = 0; i < 3; i++) drop_coin(2'b00);
        checks++;
        if (credit !== 8'd75) begin
            failures++;
            $display("FAIL midreset_setup actual=%0d required=75", credit);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({coin_in, double_wash, busy, change_valid, coin_reject, credit, change_amount} !== 21'd0) begin
            failures++;
            $display("FAIL midreset_async actual=%h required=0",
                     {coin_in, double_wash, busy, change_valid, coin_reject, credit, change_amount});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (change_valid !== 1'b0 || credit !== 8'd0) begin
            failures++;
            $display("FAIL midreset_no_refund actual=%b/%0d required=0/0", change_valid, credit);
        end
        drop_coin(2'b10);
        checks++;
        if (coin_in !== 1'b1 || credit !== 8'd100 || double_wash !== 1'b0) begin
            failures++;
            $display("FAIL midreset_direct_start actual=%b/%0d/%b required=1/100/0",
                     coin_in, credit, double_wash);
        end
        tick();
        pulse_wash_done();
    endtask

    initial begin
        test_reset();
        test_single_wash();
        test_double_wash();
        test_cancel();
        test_timeout();
        test_running_and_reject();
        test_reset_mid();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
